// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode enum and count-width helper,
// common to the single-clock and dual-clock FIFO families.
package fifo_pkg;

  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } rd_mode_e;

  // Occupancy needs one extra bit so that a full FIFO (2**a_width) is representable.
  function automatic int cnt_w(input int a_width);
    return a_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port storage array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset so the array maps onto distributed RAM.
module fifo_mem #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] waddr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic [A_WIDTH-1:0] raddr_i,
  output logic [D_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << A_WIDTH;

  logic [D_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// FWFT or registered read, synchronous flush and sticky error flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int D_WIDTH   = 32,
  parameter int A_WIDTH   = 4,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      clr_err,
  input  logic                      w_inc,
  input  logic [D_WIDTH-1:0]        w_data,
  output logic                      w_full,
  input  logic                      r_inc,
  output logic [D_WIDTH-1:0]        r_data,
  output logic                      r_empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(A_WIDTH)-1:0] count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int       DEPTH = 1 << A_WIDTH;
  localparam int       CW    = cnt_w(A_WIDTH);
  localparam rd_mode_e MODE  = (FWFT != 0) ? FWFT_ON : FWFT_OFF;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_range_err
    $error("sync_fifo: AF_THRESH=%0d outside 1..%0d", AF_THRESH, DEPTH);
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_range_err
    $error("sync_fifo: AE_THRESH=%0d outside 0..%0d", AE_THRESH, DEPTH - 1);
  end

  logic [CW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic               ovf_q,    ovf_d;
  logic               udf_q,    udf_d;
  logic               full, empty;
  logic               wr_acc, rd_acc;
  logic [D_WIDTH-1:0] mem_rdata;

  // Flags decode the registered count so they move on the same edge as count.
  always_comb begin
    full   = (count_q == DEPTH_C);
    empty  = (count_q == '0);
    wr_acc = w_inc & ~full  & ~flush;
    rd_acc = r_inc & ~empty & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end

    // A new error in the same cycle as clr_err must not be lost.
    ovf_d = (ovf_q & ~clr_err) | (w_inc & full  & ~flush);
    udf_d = (udf_q & ~clr_err) | (r_inc & empty & ~flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[A_WIDTH-1:0]),
    .wdata_i (w_data),
    .raddr_i (rd_ptr_q[A_WIDTH-1:0]),
    .rdata_o (mem_rdata)
  );

  if (MODE == FWFT_ON) begin : g_fwft
    assign r_data = mem_rdata;
  end else begin : g_reg_read
    logic [D_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (rd_acc) rdata_d = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign r_data = rdata_q;
  end

  assign w_full       = full;
  assign r_empty      = empty;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DEPTH_C);
  a_ptr_span:    assert property (@(posedge clk) disable iff (!rst_n)
                                  (wr_ptr_q - rd_ptr_q) == count_q);

endmodule
